// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers up to DEPTH
// {instr, pc+4} pairs from combinational imem, and pops to decode on ready.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  output logic [31:0]                ImemAddr,
  input  logic [31:0]                ImemData,
  input  logic                       Redirect,
  input  logic [31:0]                RedirectPC,
  input  logic                       DecodeReady,
  output logic                       InstrValid,
  output logic [31:0]                InstrOut,
  output logic [31:0]                PCPlus4Out,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc4_q   [DEPTH];

  logic          pop;
  logic          push;
  logic          valid;
  logic [31:0]   pc_plus4;
  logic          rpc_unused;

  assign rpc_unused = ^RedirectPC[1:0];

  assign valid    = (count_q != '0);
  assign pc_plus4 = fetch_pc_q + 32'd4;
  assign pop      = valid && DecodeReady && !Redirect;
  // A pop frees the head slot in the same edge, so a full queue still accepts a push.
  assign push     = !Redirect && ((count_q != CW'(DEPTH)) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (Redirect) begin
      fetch_pc_d = {RedirectPC[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (push) begin
        tail_d     = tail_q + AW'(1);
        fetch_pc_d = pc_plus4;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_pc_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage is never cleared; count_q alone decides what is visible.
  always_ff @(posedge Clk) begin
    if (push) begin
      instr_q[tail_q] <= ImemData;
      pc4_q[tail_q]   <= pc_plus4;
    end
  end

  assign ImemAddr   = fetch_pc_q;
  assign InstrValid = valid;
  assign InstrOut   = valid ? instr_q[head_q] : '0;
  assign PCPlus4Out = valid ? pc4_q[head_q]   : '0;
  assign Count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, then randomized
// traffic compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic                   Clk;
  logic                   Reset;
  logic [31:0]            ImemAddr;
  logic [31:0]            ImemData;
  logic                   Redirect;
  logic [31:0]            RedirectPC;
  logic                   DecodeReady;
  logic                   InstrValid;
  logic [31:0]            InstrOut;
  logic [31:0]            PCPlus4Out;
  logic [$clog2(DEPTH):0] Count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ImemAddr    (ImemAddr),
    .ImemData    (ImemData),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .DecodeReady (DecodeReady),
    .InstrValid  (InstrValid),
    .InstrOut    (InstrOut),
    .PCPlus4Out  (PCPlus4Out),
    .Count       (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  always_comb ImemData = imem(ImemAddr);

  typedef struct {
    logic        rst;
    logic        red;
    logic [31:0] rpc;
    logic        rdy;
    int unsigned cnt;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] addr;
  } vec_t;

  vec_t vt[$];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;

  task automatic addv(input logic rst, input logic red, input logic [31:0] rpc,
                      input logic rdy, input int unsigned cnt, input logic valid,
                      input logic [31:0] instr, input logic [31:0] pc4,
                      input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.red = red; v.rpc = rpc; v.rdy = rdy; v.cnt = cnt;
    v.valid = valid; v.instr = instr; v.pc4 = pc4; v.addr = addr;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of pairs plus the fetch address.
  task automatic model_step(input logic rst, input logic red, input logic [31:0] rpc,
                            input logic rdy);
    bit pop_m;
    bit push_m;
    if (rst) begin
      mq.delete();
      mpc = 32'h0;
    end else if (red) begin
      mq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end else begin
      pop_m  = (mq.size() > 0) && rdy;
      push_m = (mq.size() < DEPTH) || pop_m;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back({imem(mpc), mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic red, input logic [31:0] rpc,
                       input logic rdy);
    Reset       = rst;
    Redirect    = red;
    RedirectPC  = rpc;
    DecodeReady = rdy;
    model_step(rst, red, rpc, rdy);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_model();
    chk("rnd_count", 32'(Count), 32'(mq.size()));
    chk("rnd_valid", 32'(InstrValid), (mq.size() > 0) ? 32'd1 : 32'd0);
    chk("rnd_instr", InstrOut, (mq.size() > 0) ? mq[0].instr : 32'h0);
    chk("rnd_pc4", PCPlus4Out, (mq.size() > 0) ? mq[0].pc4 : 32'h0);
    chk("rnd_addr", ImemAddr, mpc);
  endtask

  initial begin
    Reset = 1'b1; Redirect = 1'b0; RedirectPC = '0; DecodeReady = 1'b0;
    mpc = 32'h0;

    // rst red rpc rdy | cnt valid instr pc4 addr
    addv(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    addv(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    addv(0, 0, 32'h0, 0, 1, 1, 32'h1000_0000, 32'h4, 32'h4);
    addv(0, 0, 32'h0, 0, 2, 1, 32'h1000_0000, 32'h4, 32'h8);
    addv(0, 0, 32'h0, 0, 3, 1, 32'h1000_0000, 32'h4, 32'hC);
    addv(0, 0, 32'h0, 0, 4, 1, 32'h1000_0000, 32'h4, 32'h10);
    addv(0, 0, 32'h0, 0, 4, 1, 32'h1000_0000, 32'h4, 32'h10);
    addv(0, 0, 32'h0, 1, 4, 1, 32'h1000_0001, 32'h8, 32'h14);
    addv(0, 0, 32'h0, 1, 4, 1, 32'h1000_0002, 32'hC, 32'h18);
    addv(0, 1, 32'h20, 1, 0, 0, 32'h0, 32'h0, 32'h20);
    addv(0, 0, 32'h0, 0, 1, 1, 32'h1000_0008, 32'h24, 32'h24);
    addv(0, 0, 32'h0, 0, 2, 1, 32'h1000_0008, 32'h24, 32'h28);
    addv(0, 0, 32'h0, 0, 3, 1, 32'h1000_0008, 32'h24, 32'h2C);
    addv(0, 1, 32'h43, 1, 0, 0, 32'h0, 32'h0, 32'h40);
    addv(0, 0, 32'h0, 1, 1, 1, 32'h1000_0010, 32'h44, 32'h44);
    addv(0, 0, 32'h0, 1, 1, 1, 32'h1000_0011, 32'h48, 32'h48);
    addv(0, 0, 32'h0, 1, 1, 1, 32'h1000_0012, 32'h4C, 32'h4C);
    addv(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    addv(0, 0, 32'h0, 0, 1, 1, 32'h4FFF_FFFF, 32'h0, 32'h0);
    addv(0, 0, 32'h0, 0, 2, 1, 32'h4FFF_FFFF, 32'h0, 32'h4);
    addv(0, 0, 32'h0, 1, 2, 1, 32'h1000_0000, 32'h4, 32'h8);
    addv(0, 0, 32'h0, 0, 3, 1, 32'h1000_0000, 32'h4, 32'hC);
    addv(0, 0, 32'h0, 0, 4, 1, 32'h1000_0000, 32'h4, 32'h10);
    addv(1, 1, 32'h80, 1, 0, 0, 32'h0, 32'h0, 32'h0);
    addv(0, 0, 32'h0, 1, 1, 1, 32'h1000_0000, 32'h4, 32'h4);

    foreach (vt[i]) begin
      cycle(vt[i].rst, vt[i].red, vt[i].rpc, vt[i].rdy);
      chk($sformatf("vec%0d_count", i), 32'(Count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_valid", i), 32'(InstrValid), 32'(vt[i].valid));
      chk($sformatf("vec%0d_instr", i), InstrOut, vt[i].instr);
      chk($sformatf("vec%0d_pc4", i), PCPlus4Out, vt[i].pc4);
      chk($sformatf("vec%0d_addr", i), ImemAddr, vt[i].addr);
    end

    // Stall hold: head outputs stay put while DecodeReady is low on a full queue.
    cycle(1, 0, 32'h0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 32'h0, 0);
      chk("stall_instr", InstrOut, 32'h1000_0000);
      chk("stall_pc4", PCPlus4Out, 32'h4);
      chk("stall_addr", ImemAddr, 32'h10);
    end

    // Randomized traffic against the model.
    cycle(1, 0, 32'h0, 0);
    check_model();
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst;
      logic        r_red;
      logic [31:0] r_rpc;
      logic        r_rdy;
      r_rst = ($urandom_range(0, 99) == 0);
      r_red = ($urandom_range(0, 15) == 0);
      r_rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
      r_rdy = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(r_rst, r_red, r_rpc, r_rdy);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
